io_seg_display: RTL and testbench
=================================

Name: io_seg_display

Overview:
- Downstream consumer of an IO output port register (e.g. out_port0) in the single-cycle CPU's memory-mapped IO path.
- Converts the 32-bit port value to six 7-segment digit codes, one per board HEX display.
- Decimal conversion uses an iterative double-dabble FSM (one bit per cycle); hex mode is a nibble pass-through.
- Digit outputs are held until a conversion completes, so the display never flickers mid-conversion.

Parameters:
- IN_WIDTH, 32, width of value_in and the number of double-dabble shift iterations.
- DEC_LIMIT, 999999, largest value displayable in decimal mode.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous active-low reset.
- value_in  input  IN_WIDTH  value to display; normally driven by an out_port register.
- hex_mode  input  1  1 = hexadecimal display, 0 = decimal display.
- blank_zeros  input  1  1 = blank leading zero digits.
- hex0..hex5  output  7 each  segment codes; hex0 is the least significant digit; bit order g f e d c b a, active low.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- overflow  output  1  high when the displayed value is out of range; registered with the hex outputs.

Behaviour:
- Reset: one clock edge with resetn=0 sets the following, regardless of state (this includes mid-conversion):
  - state=IDLE, all hex outputs = 7'b1111111 (blank), busy=0, overflow=0.
  - shadow registers last_val=0, last_mode=0, last_blank=0, and valid=0.
- IDLE:
  - Start condition: valid==0, or value_in!=last_val, or hex_mode!=last_mode, or blank_zeros!=last_blank.
  - On the start condition, capture all three inputs into the shadow registers and latch work=value_in.
  - Also compute ovf: in decimal mode, value_in>DEC_LIMIT; in hex mode, value_in[31:24]!=0.
  - Next state is SHIFT in decimal mode (cnt=0, 24-bit BCD accumulator cleared), or UPDATE in hex mode.
- SHIFT (decimal only):
  - Each cycle, add 3 to every BCD nibble >=5.
  - Then shift {bcd, work} left by one.
  - cnt increments; after IN_WIDTH shifts, go to UPDATE.
  - Only the low 6 BCD nibbles are kept; overflowed values are never shown, so the high bits are don't-care.
- UPDATE:
  - Register hex0..hex5 and overflow, set valid=1, return to IDLE.
  - If ovf: every digit shows dash 7'b0111111.
  - Otherwise, digit i is decoded from BCD nibble i (decimal) or work[4i+3:4i] (hex).
  - Blanking: if last_blank and not ovf, each leading zero digit from hex5 downward shows 7'b1111111 until the first nonzero digit. hex0 is never blanked.
- Segment codes (active low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Latency, with the start condition sampled at edge k:
  - Decimal: shifts occur on edges k+1..k+32; outputs are updated at edge k+33; busy is high after edges k..k+32.
  - Hex: outputs are updated at edge k+1.
- Input changes during SHIFT or UPDATE are ignored. The captured value completes and is displayed. The new value is detected in IDLE on the next edge and triggers a fresh conversion.
- After reset, the first conversion starts on the first edge with resetn=1, even when value_in==0.
- Steady input: no restarts; busy stays 0.

Test Plan:
- Decimal, no blanking: reset, then value_in=123456, hex_mode=0, blank_zeros=0.
  - Outputs stay blank until 33 edges after the first post-reset edge.
  - Then hex5..hex0 show 1,2,3,4,5,6 (1111001, 0100100, 0110000, 0011001, 0010010, 0000010); overflow=0, busy=0.
- Decimal, overflow: value_in=1000000.
  - All digits show 0111111, overflow=1.
  - Then value_in=999999: all digits show 9 (0010000), overflow=0.
- Hex mode: hex_mode=1, value_in=32'h00ABCDEF.
  - Outputs are updated one edge after the start; hex5..hex0 = A,b,C,d,E,F; busy high exactly one cycle.
  - Then value_in=32'h01000000: all dashes, overflow=1.
- Leading-zero blanking: blank_zeros=1, decimal, value_in=42.
  - hex5..hex2 = 1111111, hex1 = 4 (0011001), hex0 = 2 (0100100).
  - Then value_in=0: only hex0 shows 0 (1000000).
- Input change mid-conversion: value_in=500, then change it to 777 ten cycles later.
  - Display shows 000500 at the first completion.
  - A second conversion starts the following edge; display shows 000777 after it completes.
  - hex outputs never show an intermediate value.
- Reset mid-conversion: assert resetn=0 for one edge at SHIFT cnt=15.
  - Next cycle: busy=0, all hex blank, overflow=0.
  - After release, the current value_in converts from scratch with full 34-edge latency.

Source files
------------

// File: rtl/io_seg_display.sv
// Six-digit 7-segment driver for an IO output port register.
// Ports: clock, resetn (sync, active low); value_in, hex_mode,
//   blank_zeros in; hex0..hex5 (gfedcba, active low), busy,
//   overflow out. Decimal uses a one-bit-per-cycle double dabble.
module io_seg_display #(
  parameter int IN_WIDTH  = 32,
  parameter int DEC_LIMIT = 999999
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [IN_WIDTH-1:0] value_in,
  input  logic                hex_mode,
  input  logic                blank_zeros,
  output logic [6:0]          hex0,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic [6:0]          hex3,
  output logic [6:0]          hex4,
  output logic [6:0]          hex5,
  output logic                busy,
  output logic                overflow
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [IN_WIDTH-1:0] LIM = IN_WIDTH'(DEC_LIMIT);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_last_val;
  logic                r_last_mode;
  logic                r_last_blank;
  logic                r_valid;
  logic [IN_WIDTH-1:0] r_work;
  logic [23:0]         r_bcd;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf;
  logic [6:0]          r_hex [6];
  logic                r_busy;
  logic                r_overflow;

  logic                w_start;
  logic                w_ovf_in;
  logic [22:0]         w_adj;
  logic [3:0]          w_nib;
  logic                w_seen;
  logic [6:0]          w_code [6];

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_start = !r_valid
                || (value_in != r_last_val)
                || (hex_mode != r_last_mode)
                || (blank_zeros != r_last_blank);

  // Hex mode can only show the low six nibbles.
  assign w_ovf_in = hex_mode ? ((value_in >> 24) != '0)
                             : (value_in > LIM);

  // Add-3 step. The top nibble keeps only 3 bits because
  // its MSB is shifted out and never displayed.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      else
        w_adj[4*i +: 4] = r_bcd[4*i +: 4];
    end
    if (r_bcd[23:20] >= 4'd5)
      w_adj[22:20] = r_bcd[22:20] + 3'd3;
    else
      w_adj[22:20] = r_bcd[22:20];
  end

  // Scan from the top digit; blanking stops at the first
  // nonzero nibble, and hex0 always shows.
  always_comb begin
    w_seen = 1'b0;
    w_nib  = '0;
    for (int i = 0; i < 6; i++) w_code[i] = SEG_BLANK;
    for (int i = 5; i >= 0; i--) begin
      w_nib = r_last_mode ? r_work[4*i +: 4] : r_bcd[4*i +: 4];
      if (r_ovf)
        w_code[i] = SEG_DASH;
      else if (r_last_blank && !w_seen && w_nib == 4'd0 && i != 0)
        w_code[i] = SEG_BLANK;
      else
        w_code[i] = seg7(w_nib);
      if (w_nib != 4'd0) w_seen = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_last_val   <= '0;
      r_last_mode  <= 1'b0;
      r_last_blank <= 1'b0;
      r_valid      <= 1'b0;
      r_work       <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      for (int i = 0; i < 6; i++) r_hex[i] <= SEG_BLANK;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_last_val   <= value_in;
            r_last_mode  <= hex_mode;
            r_last_blank <= blank_zeros;
            r_work       <= value_in;
            r_ovf        <= w_ovf_in;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= hex_mode ? UPDATE : SHIFT;
          end
        end
        SHIFT: begin
          r_bcd  <= {w_adj, r_work[IN_WIDTH-1]};
          r_work <= r_work << 1;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < 6; i++) r_hex[i] <= w_code[i];
          r_overflow <= r_ovf;
          r_valid    <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign hex0     = r_hex[0];
  assign hex1     = r_hex[1];
  assign hex2     = r_hex[2];
  assign hex3     = r_hex[3];
  assign hex4     = r_hex[4];
  assign hex5     = r_hex[5];
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_io_seg_display.sv
// Directed bench for io_seg_display: vector table plus
// hand sequences for mid-conversion change and reset.
module tb_io_seg_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  typedef struct {
    logic [31:0] val;
    logic        hm;
    logic        bz;
    logic [41:0] disp;
    logic        ovf;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] value_in;
  logic        hex_mode;
  logic        blank_zeros;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy;
  logic        overflow;
  logic [41:0] disp;

  int total = 0;
  int bad   = 0;

  io_seg_display dut (
    .clock       (clock),
    .resetn      (resetn),
    .value_in    (value_in),
    .hex_mode    (hex_mode),
    .blank_zeros (blank_zeros),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5),
    .busy        (busy),
    .overflow    (overflow)
  );

  assign disp = {hex5, hex4, hex3, hex2, hex1, hex0};

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Step until busy drops; display must hold prev while busy.
  task automatic conv(input string nm, input int exp_lat,
                      input logic [41:0] exp_disp,
                      input logic exp_ovf,
                      input logic [41:0] prev,
                      input int chg_at,
                      input logic [31:0] chg_val);
    int  n;
    bit  held;
    bit  done;
    n = 0;
    held = 1'b1;
    done = 1'b0;
    while (!done && n < 80) begin
      step();
      n++;
      if (n == chg_at) value_in = chg_val;
      if (busy) begin
        if (disp !== prev) held = 1'b0;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: busy still %0b after %0d edges",
               nm, busy, n);
    end
    chk({nm, " latency"}, 64'(n), 64'(exp_lat));
    chk({nm, " held"}, 64'(held), 64'd1);
    chk({nm, " disp"}, 64'(disp), 64'(exp_disp));
    chk({nm, " ovf"}, 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    vec_t        vt [12];
    logic [41:0] prev;
    bit          steady;

    vt[0]  = '{32'd123456, 1'b0, 1'b0,
               {S1, S2, S3, S4, S5, S6}, 1'b0};
    vt[1]  = '{32'd1000000, 1'b0, 1'b0, {6{DS}}, 1'b1};
    vt[2]  = '{32'd999999, 1'b0, 1'b0, {6{S9}}, 1'b0};
    vt[3]  = '{32'd0, 1'b0, 1'b0, {6{S0}}, 1'b0};
    vt[4]  = '{32'h00ABCDEF, 1'b1, 1'b0,
               {SA, SB, SC, SD, SE, SF}, 1'b0};
    vt[5]  = '{32'h00FFFFFF, 1'b1, 1'b0, {6{SF}}, 1'b0};
    vt[6]  = '{32'h01000000, 1'b1, 1'b0, {6{DS}}, 1'b1};
    vt[7]  = '{32'h00000F00, 1'b1, 1'b1,
               {BL, BL, BL, SF, S0, S0}, 1'b0};
    vt[8]  = '{32'd42, 1'b0, 1'b1,
               {BL, BL, BL, BL, S4, S2}, 1'b0};
    vt[9]  = '{32'd0, 1'b0, 1'b1,
               {BL, BL, BL, BL, BL, S0}, 1'b0};
    vt[10] = '{32'd100, 1'b0, 1'b1,
               {BL, BL, BL, S1, S0, S0}, 1'b0};
    vt[11] = '{32'd1000000, 1'b0, 1'b1, {6{DS}}, 1'b1};

    resetn      = 1'b0;
    value_in    = 32'd0;
    hex_mode    = 1'b0;
    blank_zeros = 1'b0;
    step();
    step();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset disp", 64'(disp), 64'({6{BL}}));
    chk("reset ovf", 64'(overflow), 64'd0);

    resetn = 1'b1;
    conv("first zero", 34, {6{S0}}, 1'b0, {6{BL}}, -1, 32'd0);

    prev = {6{S0}};
    for (int i = 0; i < 12; i++) begin
      value_in    = vt[i].val;
      hex_mode    = vt[i].hm;
      blank_zeros = vt[i].bz;
      conv($sformatf("vec%0d", i), vt[i].hm ? 2 : 34,
           vt[i].disp, vt[i].ovf, prev, -1, 32'd0);
      prev = vt[i].disp;
    end

    value_in    = 32'd500;
    hex_mode    = 1'b0;
    blank_zeros = 1'b0;
    conv("chg first", 34, {S0, S0, S0, S5, S0, S0}, 1'b0,
         prev, 11, 32'd777);
    conv("chg second", 34, {S0, S0, S0, S7, S7, S7}, 1'b0,
         {S0, S0, S0, S5, S0, S0}, -1, 32'd0);

    steady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy !== 1'b0) steady = 1'b0;
    end
    chk("steady idle", 64'(steady), 64'd1);

    value_in = 32'd31;
    for (int i = 0; i < 16; i++) step();
    resetn = 1'b0;
    step();
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst disp", 64'(disp), 64'({6{BL}}));
    chk("midrst ovf", 64'(overflow), 64'd0);
    resetn = 1'b1;
    conv("after rst", 34, {S0, S0, S0, S0, S3, S1}, 1'b0,
         {6{BL}}, -1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
